// File: rtl/ucup_ext_mem_arb_if.sv
// Requester-side bus of the external memory arbiter: one packed lane per port.
interface ucup_ext_mem_arb_if #(
  parameter int NumPorts = 2
);
  logic [NumPorts-1:0]       mem_req_i;
  logic [NumPorts-1:0]       mem_gnt_o;
  logic [NumPorts-1:0]       mem_we_i;
  logic [NumPorts-1:0][3:0]  mem_be_i;
  logic [NumPorts-1:0][31:0] mem_addr_i;
  logic [NumPorts-1:0][31:0] mem_wdata_i;
  logic [NumPorts-1:0]       mem_rvalid_o;
  logic [NumPorts-1:0][31:0] mem_rdata_o;
  logic [NumPorts-1:0]       mem_err_o;

  modport slave (
    input  mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
    output mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_err_o
  );
  modport master (
    output mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
    input  mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_err_o
  );
endinterface

// File: rtl/ucup_ext_mem_arb.sv
// Round-robin arbiter in front of a word-addressed SRAM with a fixed-latency
// response pipeline; each port owns a registered response lane.
module ucup_ext_mem_arb_lane #(
  parameter int PW = 1,
  parameter int Id = 0
) (
  input  logic          clk_sys_i,
  input  logic          rst_sys_i,
  input  logic          vld,
  input  logic [PW-1:0] pid,
  input  logic [31:0]   data,
  input  logic          err,
  output logic          rvalid,
  output logic [31:0]   rdata,
  output logic          rerr
);
  logic hit;
  assign hit = vld && (pid == PW'(Id));

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rerr   <= 1'b0;
    end else begin
      rvalid <= hit;
      rdata  <= hit ? data : '0;
      rerr   <= hit && err;
    end
  end
endmodule

module ucup_ext_mem_arb #(
  parameter int          NumPorts      = 2,
  parameter int          MemDepthWords = 16384,
  parameter logic [31:0] BaseAddr      = 32'h00100000,
  parameter int          ReadLatency   = 1
) (
  input logic clk_sys_i,
  input logic rst_sys_i,
  ucup_ext_mem_arb_if.slave bus
);
  localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int AW = (MemDepthWords > 1) ? $clog2(MemDepthWords) : 1;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] pid;
    logic [31:0]   data;
    logic          err;
  } stage_t;

  logic [PW-1:0]       ptr, sel;
  logic                found;
  logic [NumPorts-1:0] gnt;

  // First requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!found && bus.mem_req_i[(int'(ptr) + i) % NumPorts]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr) + i) % NumPorts);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found && !rst_sys_i) gnt[sel] = 1'b1;
  end
  assign bus.mem_gnt_o = gnt;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i)   ptr <= '0;
    else if (|gnt)   ptr <= (int'(sel) == NumPorts - 1) ? '0 : PW'(sel + 1'b1);
  end

  logic [31:0]   addr, wdata;
  logic [29:0]   word_off;
  logic [3:0]    be;
  logic          we, in_rng, unused_addr_lsb;
  logic [AW-1:0] idx;

  assign addr            = bus.mem_addr_i[sel];
  assign wdata           = bus.mem_wdata_i[sel];
  assign be              = bus.mem_be_i[sel];
  assign we              = bus.mem_we_i[sel];
  assign unused_addr_lsb = ^addr[1:0];
  // Base is word aligned, so the word offset is a plain 30-bit subtraction.
  assign word_off = addr[31:2] - BaseAddr[31:2];
  assign in_rng   = (addr[31:2] >= BaseAddr[31:2]) && (word_off < 30'(MemDepthWords));
  assign idx      = word_off[AW-1:0];

  logic [31:0] mem [MemDepthWords];

  always_ff @(posedge clk_sys_i) begin
    if (|gnt && we && in_rng)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end

  stage_t st0, tail;
  always_comb begin
    st0.vld  = |gnt;
    st0.pid  = sel;
    st0.err  = !in_rng;
    st0.data = (in_rng && !we) ? mem[idx] : '0;
  end

  // ReadLatency-1 shared stages; the per-port lane register is the last one.
  generate
    if (ReadLatency == 1) begin : g_direct
      assign tail = st0;
    end else begin : g_pipe
      stage_t pipe [ReadLatency-1];
      always_ff @(posedge clk_sys_i) begin
        pipe[0] <= st0;
        for (int i = 1; i < ReadLatency - 1; i++) pipe[i] <= pipe[i-1];
        if (rst_sys_i)
          for (int i = 0; i < ReadLatency - 1; i++) pipe[i].vld <= 1'b0;
      end
      assign tail = pipe[ReadLatency-2];
    end
  endgenerate

  logic [NumPorts-1:0]       rvalid, rerr;
  logic [NumPorts-1:0][31:0] rdata;

  for (genvar p = 0; p < NumPorts; p++) begin : g_lane
    ucup_ext_mem_arb_lane #(.PW(PW), .Id(p)) u_lane (
      .clk_sys_i (clk_sys_i),
      .rst_sys_i (rst_sys_i),
      .vld       (tail.vld),
      .pid       (tail.pid),
      .data      (tail.data),
      .err       (tail.err),
      .rvalid    (rvalid[p]),
      .rdata     (rdata[p]),
      .rerr      (rerr[p])
    );
  end

  assign bus.mem_rvalid_o = rvalid;
  assign bus.mem_rdata_o  = rdata;
  assign bus.mem_err_o    = rerr;
endmodule

// File: tb/tb_ucup_ext_mem_arb.sv
// Random and directed traffic against a cycle-indexed response schedule model.
module tb_ucup_ext_mem_arb;
  localparam int          NP    = 4;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 3;
  localparam logic [31:0] BASE  = 32'h00100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ucup_ext_mem_arb_if #(.NumPorts(NP)) bus();
  ucup_ext_mem_arb #(.NumPorts(NP), .MemDepthWords(DEPTH), .BaseAddr(BASE),
                     .ReadLatency(LAT)) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .bus       (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: storage, pointer, and expected responses keyed by cycle number.
  logic [31:0]   mmem [DEPTH];
  int            mptr = 0;
  int            cyc = 0;
  logic [NP-1:0] ev [8];
  logic [NP-1:0] ee [8];
  logic [31:0]   ed [8][NP];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    int s, t, win, w;
    logic [NP-1:0] eg;
    logic [31:0] a;
    bit inr;
    for (int i = 0; i < 8; i++) begin
      ev[i] = '0; ee[i] = '0;
      for (int p = 0; p < NP; p++) ed[i][p] = '0;
    end
    forever begin
      @(negedge clk);
      s = cyc % 8;
      for (int p = 0; p < NP; p++) begin
        vectors++;
        if (bus.mem_rvalid_o[p] !== ev[s][p] || bus.mem_rdata_o[p] !== ed[s][p] ||
            bus.mem_err_o[p] !== ee[s][p]) begin
          miscompares++;
          $display("FAIL resp port%0d cyc%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b", p, cyc,
                   bus.mem_rvalid_o[p], bus.mem_rdata_o[p], bus.mem_err_o[p],
                   ev[s][p], ed[s][p], ee[s][p]);
        end
        ed[s][p] = '0;
      end
      ev[s] = '0; ee[s] = '0;
      eg = '0; win = 0;
      if (rst) begin
        mptr = 0;
        for (int i = 0; i < 8; i++) begin
          ev[i] = '0; ee[i] = '0;
          for (int p = 0; p < NP; p++) ed[i][p] = '0;
        end
      end else begin
        for (int i = 0; i < NP; i++)
          if (eg == '0 && bus.mem_req_i[(mptr + i) % NP]) begin
            win = (mptr + i) % NP;
            eg[win] = 1'b1;
          end
      end
      vectors++;
      if (bus.mem_gnt_o !== eg) begin
        miscompares++;
        $display("FAIL gnt cyc%0d: got %b want %b", cyc, bus.mem_gnt_o, eg);
      end
      if (eg != '0) begin
        a   = bus.mem_addr_i[win];
        inr = (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
        w   = inr ? int'((a - BASE) >> 2) : 0;
        t   = (cyc + LAT) % 8;
        ev[t][win] = 1'b1;
        ee[t][win] = !inr;
        ed[t][win] = (inr && !bus.mem_we_i[win]) ? mmem[w] : 32'h0;
        if (inr && bus.mem_we_i[win])
          for (int b = 0; b < 4; b++)
            if (bus.mem_be_i[win][b]) mmem[w][8*b +: 8] = bus.mem_wdata_i[win][8*b +: 8];
        mptr = (win + 1) % NP;
      end
      cyc++;
    end
  end

  task automatic txn(input int p, input bit we, input logic [3:0] be, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    rd = 'x; er = 1'bx; lat = -1;
    @(posedge clk); #1;
    bus.mem_req_i[p] = 1'b1; bus.mem_we_i[p] = we; bus.mem_be_i[p] = be;
    bus.mem_addr_i[p] = a; bus.mem_wdata_i[p] = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_gnt_o[p] && n < 50);
    if (!bus.mem_gnt_o[p]) begin
      vectors++; miscompares++;
      $display("FAIL gnt_timeout port%0d: got no grant want grant within 50 cycles", p);
      @(posedge clk); #1; bus.mem_req_i[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.mem_req_i[p] = 1'b0;
    n = 1;
    while (!bus.mem_rvalid_o[p] && n < 10) begin @(posedge clk); #1; n++; end
    rd = bus.mem_rdata_o[p]; er = bus.mem_err_o[p]; lat = n;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return BASE - 32'd4;
      2: return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 3));
      3: return $urandom;
      default: return BASE + 32'($urandom_range(0, DEPTH - 1) << 2) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, cnt;
    logic [NP-1:0] g;
    bus.mem_req_i = '0; bus.mem_we_i = '0; bus.mem_be_i = '0;
    bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int w = 0; w < DEPTH; w++)
      txn(w % NP, 1'b1, 4'hF, BASE + 32'(4 * w), $urandom, rd, er, lat);

    txn(0, 1'b1, 4'hF, 32'h00100010, 32'hDEADBEEF, rd, er, lat);
    chk("wr_latency", 32'(lat), 32'(LAT));
    chk("wr_rdata", rd, 32'h0);
    txn(0, 1'b0, 4'hF, 32'h00100010, 32'h0, rd, er, lat);
    chk("rd_latency", 32'(lat), 32'(LAT));
    chk("rd_deadbeef", rd, 32'hDEADBEEF);
    chk("rd_err", {31'b0, er}, 32'h0);
    txn(1, 1'b1, 4'h0, 32'h00100012, 32'h0, rd, er, lat);
    chk("be0_err", {31'b0, er}, 32'h0);
    txn(1, 1'b0, 4'hF, 32'h00100013, 32'h0, rd, er, lat);
    chk("be0_unchanged", rd, 32'hDEADBEEF);

    txn(1, 1'b1, 4'hF, 32'h00100020, 32'hAABBCCDD, rd, er, lat);
    txn(1, 1'b1, 4'b0101, 32'h00100020, 32'h11223344, rd, er, lat);
    txn(2, 1'b0, 4'hF, 32'h00100020, 32'h0, rd, er, lat);
    chk("byte_merge", rd, 32'hAA22CC44);

    txn(0, 1'b1, 4'hF, BASE, 32'h12345678, rd, er, lat);
    txn(3, 1'b0, 4'hF, 32'h0, 32'h0, rd, er, lat);
    chk("oor_rd_err", {31'b0, er}, 32'h1);
    chk("oor_rd_data", rd, 32'h0);
    txn(3, 1'b1, 4'hF, BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, rd, er, lat);
    chk("oor_wr_err", {31'b0, er}, 32'h1);
    txn(3, 1'b0, 4'hF, BASE, 32'h0, rd, er, lat);
    chk("oor_no_alias", rd, 32'h12345678);
    txn(2, 1'b1, 4'hF, BASE + 32'(4 * DEPTH - 4), 32'hCAFEF00D, rd, er, lat);
    txn(2, 1'b0, 4'hF, BASE + 32'(4 * DEPTH - 4), 32'h0, rd, er, lat);
    chk("last_word", rd, 32'hCAFEF00D);
    chk("last_word_err", {31'b0, er}, 32'h0);

    // Two ports hammering from a fresh reset alternate starting with port 0.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.mem_we_i[1:0] = 2'b00; bus.mem_addr_i[0] = BASE; bus.mem_addr_i[1] = BASE + 32'd4;
    bus.mem_req_i[1:0] = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("contend_%0d", i), 32'(bus.mem_gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    @(posedge clk); #1 bus.mem_req_i = '0;
    repeat (LAT + 1) @(posedge clk);

    // Reset one cycle after a grant kills the response and re-homes the pointer.
    #1 bus.mem_req_i[2] = 1'b1; bus.mem_we_i[2] = 1'b0; bus.mem_addr_i[2] = BASE;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(bus.mem_gnt_o), 32'h4);
    @(posedge clk); #1;
    bus.mem_req_i[2] = 1'b0; rst = 1'b1;
    bus.mem_req_i[1] = 1'b1; bus.mem_req_i[3] = 1'b1;
    bus.mem_we_i[3] = 1'b0; bus.mem_addr_i[3] = BASE;
    cnt = 0;
    @(negedge clk);
    chk("rst_gnt_zero", 32'(bus.mem_gnt_o), 32'h0);
    cnt += int'(bus.mem_rvalid_o[2]);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", 32'(bus.mem_gnt_o), 32'h2);
    cnt += int'(bus.mem_rvalid_o[2]);
    @(posedge clk); #1 bus.mem_req_i[1] = 1'b0;
    @(negedge clk);
    cnt += int'(bus.mem_rvalid_o[2]);
    @(posedge clk); #1 bus.mem_req_i[3] = 1'b0;
    repeat (4) begin @(negedge clk); cnt += int'(bus.mem_rvalid_o[2]); end
    chk("killed_rvalid", 32'(cnt), 32'h0);

    // Random traffic with occasional resets; requests held until granted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); g = bus.mem_gnt_o;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NP; p++)
        if (!bus.mem_req_i[p] || g[p]) begin
          bus.mem_req_i[p]   = ($urandom_range(0, 99) < 70);
          bus.mem_we_i[p]    = 1'($urandom);
          bus.mem_be_i[p]    = 4'($urandom);
          bus.mem_addr_i[p]  = rand_addr();
          bus.mem_wdata_i[p] = $urandom;
        end
    end
    @(negedge clk); g = bus.mem_gnt_o;
    @(posedge clk); #1 rst = 1'b0; bus.mem_req_i = '0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ucup_ext_mem_arb.md
UCUP_EXT_MEM_ARB -- requirements
Module: ucup_ext_mem_arb

Interface
REQ-001 The module SHALL be clocked by a single clock, clk_sys_i; reset is synchronous and active-high on rst_sys_i.
REQ-002 Parameter NumPorts, default 2: number of requester ports; legal range 1..8.
REQ-003 Parameter MemDepthWords, default 16384: number of 32-bit words of internal storage; power of two.
REQ-004 Parameter BaseAddr, default 32'h00100000: byte address of word 0; aligned to MemDepthWords*4.
REQ-005 Parameter ReadLatency, default 1: cycles from grant to rvalid; legal range 1..4.
REQ-006 Port clk_sys_i, input, 1: system clock.
REQ-007 Port rst_sys_i, input, 1: synchronous active-high reset.
REQ-008 Port mem_req_i, input, [NumPorts] x 1: per-port request.
REQ-009 Port mem_gnt_o, output, [NumPorts] x 1: per-port grant.
REQ-010 Port mem_we_i, input, [NumPorts] x 1: write enable; 0 = read.
REQ-011 Port mem_be_i, input, [NumPorts] x 4: byte enables.
REQ-012 Port mem_addr_i, input, [NumPorts] x 32: byte address.
REQ-013 Port mem_wdata_i, input, [NumPorts] x 32: write data.
REQ-014 Port mem_rvalid_o, output, [NumPorts] x 1: response valid.
REQ-015 Port mem_rdata_o, output, [NumPorts] x 32: read data.
REQ-016 Port mem_err_o, output, [NumPorts] x 1: error flag, qualified by mem_rvalid_o.

Function
REQ-017 Grant: mem_gnt_o SHALL be combinational; at most one bit is high per cycle, and only for a port whose mem_req_i is high.
REQ-018 Arbitration: round-robin from pointer ptr; winner = first requesting port at or after ptr, modulo NumPorts.
REQ-019 Pointer update: on a grant to port k, ptr becomes (k+1) mod NumPorts at the next edge; with no grant, ptr holds.
REQ-020 Requester rule: req, we, be, addr and wdata are held stable until gnt; the block does not check this.
REQ-021 Address decode:
- word index = (addr - BaseAddr) >> 2;
- in range iff BaseAddr <= addr < BaseAddr + 4*MemDepthWords;
- addr[1:0] ignored.
REQ-022 Write: granted, in range, we=1 updates at the grant-cycle edge only the bytes with be[b]=1; be=0000 writes nothing, no error.
REQ-023 Read: granted, in range, we=0 returns the word as stored after all writes granted in earlier cycles.
REQ-024 Response: every grant (read or write) produces exactly one mem_rvalid_o pulse on the same port, exactly ReadLatency cycles after the grant cycle.
REQ-025 Pipeline: the response pipeline is ReadLatency stages deep, each carrying valid, port id, data and err; a new grant is accepted every cycle, with no back-pressure.
REQ-026 Data on response:
- reads: mem_rdata_o = stored word;
- writes: mem_rdata_o = 0;
- mem_rdata_o = 0 whenever mem_rvalid_o = 0.
REQ-027 Out of range: no storage update, mem_err_o = 1 with the response, mem_rdata_o = 0.
REQ-028 Outputs mem_rvalid_o, mem_rdata_o and mem_err_o SHALL be registered; only mem_gnt_o is combinational.

Reset
REQ-029 While rst_sys_i = 1:
- mem_gnt_o = 0;
- ptr = 0;
- all pipeline valid bits cleared;
- next cycle mem_rvalid_o = 0, mem_err_o = 0, mem_rdata_o = 0.
REQ-030 Reset mid-operation discards all in-flight responses with no late rvalid; storage contents are not cleared by reset.

Verification
REQ-031 Write/read, ReadLatency=1: port0 write 32'hDEADBEEF to 0x00100010 with be=1111, then read -> rvalid pulse 1 cycle after each grant, rdata = 32'hDEADBEEF, err = 0.
REQ-032 Byte enables: write 32'h11223344 with be=0101 over stored 32'hAABBCCDD -> read returns 32'hAA22CC44.
REQ-033 Contention, NumPorts=2: both ports request continuously from reset -> grants alternate port0, port1, port0, ...; each port's rvalid count equals its grant count.
REQ-034 Out of range: read of 0x00000000 and write to BaseAddr+4*MemDepthWords -> err = 1, rdata = 0, storage unchanged.
REQ-035 Latency sweep, ReadLatency=4: back-to-back reads on 4 ports -> rvalid exactly 4 cycles after each grant, in grant order, at one per cycle.
REQ-036 Reset mid-flight, ReadLatency=3: assert rst_sys_i one cycle after a grant -> no rvalid appears, ptr = 0, and the first post-reset grant goes to the lowest requesting port.
